// File: rtl/simon_round_ctrl.sv
// Simon round sequencer: plays a latched switch-index pattern on LED, waits for
// the switches to be cleared, then scores cumulative switch flips against it.
module simon_round_ctrl #(
    parameter int SEQ_LEN        = 7,
    parameter int ON_CYCLES      = 500,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int AUTO_START     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3*SEQ_LEN-1:0] pattern_in,
    input  logic [7:0]           SW,
    output logic [7:0]           LED,
    output logic [6:0]           seg0,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SHOW_ON    = 3'd1;
    localparam logic [2:0] S_SHOW_GAP   = 3'd2;
    localparam logic [2:0] S_WAIT_CLEAR = 3'd3;
    localparam logic [2:0] S_CAPTURE    = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam int CMAX_OG = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CMAX    = (CMAX_OG > TIMEOUT_CYCLES) ? CMAX_OG : TIMEOUT_CYCLES;
    localparam int CW      = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    K_LAST   = 3'(SEQ_LEN - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;

    logic [2:0]           state, state_n;
    logic [2:0]           k, k_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3*SEQ_LEN-1:0] pat_q, pat_n;
    logic                 verdict, verdict_n;
    logic                 armed, armed_n;
    logic [7:0]           sw_m, sw_s, sw_p;
    logic [7:0]           delta, step_bit;
    logic [2:0]           cur_idx, nxt_idx;
    logic [7:0]           led_n;
    logic [6:0]           seg_n;

    assign delta    = sw_s ^ sw_p;
    assign cur_idx  = pat_q[3*k +: 3];
    assign step_bit = 8'b1 << cur_idx;

    // Next-state logic; outputs are registered from the next-state values so
    // they change on the same edge as the state itself.
    always_comb begin
        state_n   = state;
        k_n       = k;
        cnt_n     = cnt;
        pat_n     = pat_q;
        verdict_n = verdict;
        armed_n   = armed;
        case (state)
            S_IDLE, S_DONE: begin
                if (start || (AUTO_START != 0 && armed)) begin
                    pat_n     = pattern_in;
                    k_n       = 3'd0;
                    cnt_n     = '0;
                    verdict_n = 1'b0;
                    armed_n   = 1'b0;
                    state_n   = S_SHOW_ON;
                end
            end
            S_SHOW_ON: begin
                if (cnt == ON_LAST) begin
                    cnt_n   = '0;
                    state_n = S_SHOW_GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_SHOW_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (k == K_LAST) begin
                        k_n     = 3'd0;
                        state_n = S_WAIT_CLEAR;
                    end else begin
                        k_n     = k + 3'd1;
                        state_n = S_SHOW_ON;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT_CLEAR: begin
                if (sw_s == 8'd0) begin
                    cnt_n   = '0;
                    state_n = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // A step must raise exactly the expected switch and nothing else.
                if (delta != 8'd0) begin
                    if (delta == step_bit && sw_s[cur_idx]) begin
                        cnt_n = '0;
                        if (k == K_LAST) begin
                            verdict_n = 1'b1;
                            state_n   = S_DONE;
                        end else begin
                            k_n = k + 3'd1;
                        end
                    end else begin
                        verdict_n = 1'b0;
                        state_n   = S_DONE;
                    end
                end else if (TIMEOUT_CYCLES != 0 && cnt == TMO_LAST) begin
                    verdict_n = 1'b0;
                    state_n   = S_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign nxt_idx = pat_n[3*k_n +: 3];

    always_comb begin
        led_n = 8'd0;
        seg_n = SEG_BLANK;
        case (state_n)
            S_SHOW_ON: led_n = 8'b1 << nxt_idx;
            S_CAPTURE: led_n = sw_m;
            S_DONE:    seg_n = verdict_n ? SEG_ONE : SEG_ZERO;
            default:   led_n = 8'd0;
        endcase
    end

    // Synchroniser and history run in every state so delta is valid on CAPTURE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            k       <= 3'd0;
            cnt     <= '0;
            pat_q   <= '0;
            verdict <= 1'b0;
            armed   <= 1'b1;
            sw_m    <= 8'd0;
            sw_s    <= 8'd0;
            sw_p    <= 8'd0;
            LED     <= 8'd0;
            seg0    <= SEG_BLANK;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            cnt     <= cnt_n;
            pat_q   <= pat_n;
            verdict <= verdict_n;
            armed   <= armed_n;
            sw_m    <= SW;
            sw_s    <= sw_m;
            sw_p    <= sw_s;
            LED     <= led_n;
            seg0    <= seg_n;
            busy    <= (state_n != S_IDLE) && (state_n != S_DONE);
            done    <= (state_n == S_DONE);
            pass    <= (state_n == S_DONE) && verdict_n;
        end
    end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl: directed round scenarios plus
// randomized rounds scored by a switch-set reference model.
module tb_simon_round_ctrl;

    localparam int LEN  = 7;
    localparam int ON   = 12;
    localparam int GAP  = 6;
    localparam int TMO  = 200;
    localparam int STEP = ON + GAP;
    localparam int PLAY = LEN * STEP;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DIG0  = 7'b1000000;
    localparam logic [6:0] DIG1  = 7'b1111001;

    typedef int seq_t[LEN];

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic               start_a = 1'b0, start_b = 1'b0;
    logic [3*LEN-1:0]   pat_a = '0, pat_b = '0;
    logic [7:0]         sw_a = 8'd0, sw_b = 8'd0;
    logic [7:0]         led_a, led_b;
    logic [6:0]         seg_a, seg_b;
    logic               busy_a, busy_b, done_a, done_b, pass_a, pass_b;

    int   vectors = 0;
    int   miscompares = 0;
    seq_t seq;
    logic [7:0] moves[$];
    bit   early_done;

    always #5 clk = ~clk;

    simon_round_ctrl #(.SEQ_LEN(LEN), .ON_CYCLES(ON), .GAP_CYCLES(GAP),
                       .TIMEOUT_CYCLES(TMO), .AUTO_START(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pattern_in(pat_a), .SW(sw_a),
        .LED(led_a), .seg0(seg_a), .busy(busy_a), .done(done_a), .pass(pass_a));

    simon_round_ctrl #(.SEQ_LEN(LEN), .ON_CYCLES(ON), .GAP_CYCLES(GAP),
                       .TIMEOUT_CYCLES(TMO), .AUTO_START(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pattern_in(pat_b), .SW(sw_b),
        .LED(led_b), .seg0(seg_b), .busy(busy_b), .done(done_b), .pass(pass_b));

    function automatic logic [3*LEN-1:0] pack(input seq_t s);
        logic [3*LEN-1:0] v;
        v = '0;
        for (int i = 0; i < LEN; i++) v[3*i +: 3] = 3'(s[i]);
        return v;
    endfunction

    function automatic logic [7:0] bit_of(input int idx);
        return 8'd1 << idx;
    endfunction

    // Reference: every move must equal the switches already up plus the next
    // pattern switch newly raised; anything else decides a failed round.
    function automatic void score(output bit ok, output int at);
        logic [7:0] held, want;
        int k;
        held = 8'd0;
        k = 0;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < moves.size(); i++) begin
            want = held | bit_of(seq[k]);
            if (moves[i] != want || want == held) begin
                ok = 1'b0;
                at = i;
                return;
            end
            held = moves[i];
            k++;
            if (k == LEN) begin
                ok = 1'b1;
                at = i;
                return;
            end
        end
    endfunction

    task automatic round_by_reset();
        pat_a = pack(seq);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic round_by_start();
        pat_a   = pack(seq);
        sw_a    = 8'd0;
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic wait_capture();
        repeat (PLAY + 2) @(negedge clk);
    endtask

    // Drives moves[0..upto] two clocks apart, then counts clocks until done.
    task automatic play_moves(input int upto, output int lat);
        early_done = 1'b0;
        for (int i = 0; i <= upto; i++) begin
            if (done_a) early_done = 1'b1;
            sw_a = moves[i];
            if (i < upto) begin
                @(negedge clk);
                if (done_a) early_done = 1'b1;
                @(negedge clk);
            end
        end
        lat = 99;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (done_a) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (led_a !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_led: got %b want %b", led_a, 8'd0); end
        vectors++; if (seg_a !== BLANK) begin miscompares++; $display("[TB] FAIL reset_seg: got %b want %b", seg_a, BLANK); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done_a); end
        vectors++; if (pass_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pass: got %b want 0", pass_a); end
        vectors++; if (seg_b !== BLANK) begin miscompares++; $display("[TB] FAIL reset_seg_b: got %b want %b", seg_b, BLANK); end
    endtask

    task automatic test_playback_pass();
        logic [7:0] exp, held;
        bit ok;
        int at, lat;
        seq = '{5, 3, 7, 6, 4, 1, 2};
        sw_a = 8'd0;
        round_by_reset();
        for (int j = 0; j < PLAY; j++) begin
            exp = ((j % STEP) < ON) ? bit_of(seq[j / STEP]) : 8'd0;
            vectors++; if (led_a !== exp) begin miscompares++; $display("[TB] FAIL play_led j=%0d: got %b want %b", j, led_a, exp); end
            vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("[TB] FAIL play_busy j=%0d: got %b want 1", j, busy_a); end
            @(negedge clk);
        end
        vectors++; if (led_a !== 8'd0) begin miscompares++; $display("[TB] FAIL post_play_led: got %b want 0", led_a); end
        repeat (2) @(negedge clk);
        moves.delete();
        held = 8'd0;
        for (int i = 0; i < LEN; i++) begin
            held |= bit_of(seq[i]);
            moves.push_back(held);
        end
        score(ok, at);
        play_moves(at, lat);
        vectors++; if (early_done !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_early_done: got 1 want 0"); end
        vectors++; if (lat > 4) begin miscompares++; $display("[TB] FAIL pass_latency: got %0d clocks want <=4", lat); end
        vectors++; if (pass_a !== ok) begin miscompares++; $display("[TB] FAIL pass_verdict: got %b want %b", pass_a, ok); end
        vectors++; if (seg_a !== DIG1) begin miscompares++; $display("[TB] FAIL pass_seg: got %b want %b", seg_a, DIG1); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_fall();
        logic [7:0] held;
        bit ok;
        int at, lat;
        seq = '{5, 3, 7, 6, 4, 1, 2};
        sw_a = 8'd0;
        round_by_reset();
        wait_capture();
        moves.delete();
        held = 8'd0;
        for (int i = 0; i < 4; i++) begin
            held |= bit_of(seq[i]);
            moves.push_back(held);
        end
        moves.push_back(held & ~bit_of(3));
        score(ok, at);
        play_moves(at, lat);
        vectors++; if (early_done !== 1'b0) begin miscompares++; $display("[TB] FAIL fall_early_done: got 1 want 0"); end
        vectors++; if (lat > 4) begin miscompares++; $display("[TB] FAIL fall_latency: got %0d clocks want <=4", lat); end
        vectors++; if (pass_a !== ok) begin miscompares++; $display("[TB] FAIL fall_verdict: got %b want %b", pass_a, ok); end
        vectors++; if (seg_a !== DIG0) begin miscompares++; $display("[TB] FAIL fall_seg: got %b want %b", seg_a, DIG0); end
        sw_a = 8'hff; repeat (3) @(negedge clk);
        sw_a = 8'h20; repeat (3) @(negedge clk);
        sw_a = 8'h00; repeat (4) @(negedge clk);
        vectors++; if (seg_a !== DIG0) begin miscompares++; $display("[TB] FAIL fall_seg_hold: got %b want %b", seg_a, DIG0); end
        vectors++; if (done_a !== 1'b1) begin miscompares++; $display("[TB] FAIL fall_done_hold: got %b want 1", done_a); end
    endtask

    task automatic test_double();
        logic [7:0] s_prev, s_now;
        bit ok;
        int at, seen;
        seq = '{5, 3, 7, 6, 4, 1, 2};
        sw_a = 8'd0;
        round_by_reset();
        wait_capture();
        moves.delete();
        moves.push_back(bit_of(5));
        moves.push_back(bit_of(5) | bit_of(3) | bit_of(7));
        score(ok, at);
        s_prev = sw_a;
        seen = -1;
        for (int c = 0; c < 10; c++) begin
            s_now = sw_a;
            if (!done_a) begin
                vectors++; if (led_a !== s_prev) begin miscompares++; $display("[TB] FAIL double_mirror c=%0d: got %b want %b", c, led_a, s_prev); end
            end else if (seen < 0) begin
                seen = c;
            end
            s_prev = s_now;
            if (c == 0) sw_a = moves[0];
            if (c == 2) sw_a = moves[at];
            @(negedge clk);
        end
        vectors++; if (seen <= 2 || seen > 6) begin miscompares++; $display("[TB] FAIL double_done_clock: got %0d want 3..6", seen); end
        vectors++; if (pass_a !== ok) begin miscompares++; $display("[TB] FAIL double_verdict: got %b want %b", pass_a, ok); end
        vectors++; if (seg_a !== DIG0) begin miscompares++; $display("[TB] FAIL double_seg: got %b want %b", seg_a, DIG0); end
        vectors++; if (led_a !== 8'd0) begin miscompares++; $display("[TB] FAIL double_led_done: got %b want 0", led_a); end
    endtask

    task automatic test_hold_timeout();
        int seen;
        seq = '{5, 3, 7, 6, 4, 1, 2};
        sw_a = 8'h01;
        round_by_reset();
        repeat (PLAY + TMO + 20) @(negedge clk);
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_busy: got %b want 1", busy_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_done: got %b want 0", done_a); end
        vectors++; if (led_a !== 8'd0) begin miscompares++; $display("[TB] FAIL hold_led: got %b want 0", led_a); end
        sw_a = 8'h00;
        seen = -1;
        for (int c = 1; c <= TMO + 8; c++) begin
            @(negedge clk);
            if (done_a) begin
                seen = c;
                break;
            end
        end
        vectors++; if (seen != TMO + 3) begin miscompares++; $display("[TB] FAIL timeout_clock: got %0d want %0d", seen, TMO + 3); end
        vectors++; if (pass_a !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_pass: got %b want 0", pass_a); end
        vectors++; if (seg_a !== DIG0) begin miscompares++; $display("[TB] FAIL timeout_seg: got %b want %b", seg_a, DIG0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        seq = '{5, 3, 7, 6, 4, 1, 2};
        sw_a = 8'd0;
        round_by_reset();
        repeat (3 * STEP + ON / 2) @(negedge clk);
        vectors++; if (led_a !== bit_of(seq[3])) begin miscompares++; $display("[TB] FAIL mid_led_step3: got %b want %b", led_a, bit_of(seq[3])); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (led_a !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_rst_led: got %b want 0", led_a); end
        vectors++; if (seg_a !== BLANK) begin miscompares++; $display("[TB] FAIL mid_rst_seg: got %b want %b", seg_a, BLANK); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy_a); end
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j <= ON; j++) begin
            exp = (j < ON) ? bit_of(seq[0]) : 8'd0;
            vectors++; if (led_a !== exp) begin miscompares++; $display("[TB] FAIL replay_led j=%0d: got %b want %b", j, led_a, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int pool[8];
        int j, tmp, at, lat;
        bit ok;
        logic [7:0] held, want, bad;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 8; i++) pool[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = pool[i]; pool[i] = pool[j]; pool[j] = tmp;
            end
            for (int i = 0; i < LEN; i++)
                seq[i] = (r % 3 == 2) ? $urandom_range(0, 7) : pool[i];
            moves.delete();
            held = 8'd0;
            for (int i = 0; i < LEN; i++) begin
                want = held | bit_of(seq[i]);
                if ($urandom_range(0, 9) == 0 || want == held) begin
                    do bad = 8'($urandom_range(0, 255)); while (bad == held || bad == want);
                    moves.push_back(bad);
                    break;
                end
                moves.push_back(want);
                held = want;
            end
            score(ok, at);
            if (r == 0) begin
                sw_a = 8'd0;
                round_by_reset();
            end else begin
                round_by_start();
            end
            wait_capture();
            play_moves(at, lat);
            vectors++; if (early_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rand%0d_early_done: got 1 want 0", r); end
            vectors++; if (lat > 4) begin miscompares++; $display("[TB] FAIL rand%0d_latency: got %0d want <=4", r, lat); end
            vectors++; if (pass_a !== ok) begin miscompares++; $display("[TB] FAIL rand%0d_verdict: got %b want %b", r, pass_a, ok); end
            vectors++; if (seg_a !== (ok ? DIG1 : DIG0)) begin miscompares++; $display("[TB] FAIL rand%0d_seg: got %b want %b", r, seg_a, ok ? DIG1 : DIG0); end
        end
    endtask

    task automatic test_manual_start();
        seq_t sa, sb;
        int seen;
        sa = '{0, 1, 2, 3, 4, 5, 6};
        sb = '{7, 6, 5, 4, 3, 2, 1};
        repeat (5) @(negedge clk);
        vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("[TB] FAIL man_idle_busy: got %b want 0", busy_b); end
        vectors++; if (led_b !== 8'd0) begin miscompares++; $display("[TB] FAIL man_idle_led: got %b want 0", led_b); end
        pat_b = pack(sa);
        sw_b = 8'd0;
        start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        vectors++; if (led_b !== bit_of(sa[0])) begin miscompares++; $display("[TB] FAIL man_step0: got %b want %b", led_b, bit_of(sa[0])); end
        vectors++; if (busy_b !== 1'b1) begin miscompares++; $display("[TB] FAIL man_busy: got %b want 1", busy_b); end
        repeat (STEP + 2) @(negedge clk);
        pat_b = pack(sb);
        start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        vectors++; if (led_b !== bit_of(sa[1])) begin miscompares++; $display("[TB] FAIL man_busy_start_ignored: got %b want %b", led_b, bit_of(sa[1])); end
        repeat (STEP) @(negedge clk);
        vectors++; if (led_b !== bit_of(sa[2])) begin miscompares++; $display("[TB] FAIL man_step2_old_pattern: got %b want %b", led_b, bit_of(sa[2])); end
        repeat (PLAY - 2 * STEP - 1) @(negedge clk);
        sw_b = ~bit_of(sa[0]);
        seen = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (done_b) begin
                seen = c;
                break;
            end
        end
        vectors++; if (seen < 1 || seen > 4) begin miscompares++; $display("[TB] FAIL man_fail_latency: got %0d want 1..4", seen); end
        vectors++; if (seg_b !== DIG0) begin miscompares++; $display("[TB] FAIL man_fail_seg: got %b want %b", seg_b, DIG0); end
        sw_b = 8'd0;
        start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        vectors++; if (seg_b !== BLANK) begin miscompares++; $display("[TB] FAIL man_restart_seg: got %b want %b", seg_b, BLANK); end
        vectors++; if (done_b !== 1'b0) begin miscompares++; $display("[TB] FAIL man_restart_done: got %b want 0", done_b); end
        vectors++; if (led_b !== bit_of(sb[0])) begin miscompares++; $display("[TB] FAIL man_new_step0: got %b want %b", led_b, bit_of(sb[0])); end
        repeat (STEP) @(negedge clk);
        vectors++; if (led_b !== bit_of(sb[1])) begin miscompares++; $display("[TB] FAIL man_new_step1: got %b want %b", led_b, bit_of(sb[1])); end
    endtask

    initial begin
        test_reset();
        test_playback_pass();
        test_fall();
        test_double();
        test_hold_timeout();
        test_reset_mid();
        test_random();
        test_manual_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
Round sequencer for the Simon game. It plays a latched 7-step pattern on LED, waits for all switches to be cleared, then scores the player's cumulative switch flips against the pattern. It reports pass/fail on seg0 as "1"/"0" and sits between the pattern source and the board I/O (SW, LED, seg0).

Parameters:
SEQ_LEN, 7, number of steps per round (1..8).
ON_CYCLES, 500, clocks each pattern LED is lit.
GAP_CYCLES, 250, clocks of dark LED between steps and after the last step.
TIMEOUT_CYCLES, 25000, maximum clocks allowed between accepted inputs during capture; 0 disables the timeout.
AUTO_START, 1, when 1 a round starts on the first clock after rst deasserts, with no start pulse needed.

Ports:
clk  in  1  system clock, 50 MHz.
rst  in  1  synchronous, active-high reset.
start  in  1  one-clock pulse that begins a round; accepted in IDLE or DONE only.
pattern_in  in  3*SEQ_LEN  step i is the switch index held in pattern_in[3*i +: 3].
SW  in  8  raw player switches, asynchronous.
LED  out  8  pattern playback during SHOW; mirrors synchronised SW during CAPTURE; 0 otherwise.
seg0  out  7  active-low digit: blank 7'b1111111, "0" 7'b1000000, "1" 7'b1111001.
busy  out  1  high in every state except IDLE and DONE.
done  out  1  high while in DONE.
pass  out  1  verdict; valid only while done=1, otherwise 0.

Behaviour:
- Reset:
  - rst sampled high puts the block in IDLE on the next edge.
  - All outputs are registered: LED=0, seg0=blank, busy=0, done=0, pass=0.
  - The step index, counters, latched pattern and synchroniser/history flops are cleared.
  - Reset asserted mid-round aborts the round with no verdict.
- SW path:
  - Two-flop synchroniser produces sw_s.
  - sw_p = sw_s delayed one clock, updated every cycle in every state.
  - delta = sw_s ^ sw_p.
- States: IDLE, SHOW_ON, SHOW_GAP, WAIT_CLEAR, CAPTURE, DONE.
- IDLE:
  - On start, or on the first clock after reset when AUTO_START=1: latch pattern_in, set k=0, go to SHOW_ON.
  - With AUTO_START=1, the block leaves IDLE only after reset.
- SHOW_ON:
  - LED = one-hot(pat[k]) for exactly ON_CYCLES clocks, then go to SHOW_GAP.
- SHOW_GAP:
  - LED = 0 for exactly GAP_CYCLES clocks.
  - If k < SEQ_LEN-1, increment k and go to SHOW_ON; otherwise set k=0 and go to WAIT_CLEAR.
  - Total playback is SEQ_LEN*(ON_CYCLES+GAP_CYCLES) clocks: 5250 at defaults.
- WAIT_CLEAR:
  - LED = 0. Stay while sw_s != 0; go to CAPTURE on the first clock with sw_s == 0.
  - No timeout applies in this state.
- CAPTURE:
  - LED = sw_s. The timeout counter runs and restarts on every accepted step.
  - When delta != 0, the step is accepted only if delta == one-hot(pat[k]) AND sw_s[pat[k]] == 1.
  - Any other nonzero delta fails the round: a falling bit, a wrong bit, or two or more bits changing in the same clock.
  - Accepted step with k == SEQ_LEN-1: go to DONE with pass=1. Otherwise increment k.
  - Counter reaching TIMEOUT_CYCLES with no accepted step (TIMEOUT_CYCLES != 0): go to DONE with pass=0.
  - A duplicated pattern index cannot be satisfied and therefore ends in failure or timeout. No special handling.
- DONE:
  - seg0 shows "1" if pass, else "0". busy=0, done=1.
  - Further SW activity is ignored.
  - start restarts from the IDLE action: seg0 returns to blank on the same edge that enters SHOW_ON.
- Latency:
  - An SW edge at the pins produces the done/seg0 update no later than 4 clocks after it: 2 synchroniser clocks, 1 history clock, 1 registered decision.
  - Inputs 2 clocks apart must each be scored individually.
- start while busy=1 is ignored.
- rst and start high on the same edge: rst wins.

Test Plan:
1. AUTO_START=1, pattern 5,3,7,6,4,1,2. After reset, check LED one-hot sequence and timing (ON/GAP exact), then raise SW5,3,7,6,4,1,2 cumulatively, 2 clocks apart -> done=1, pass=1, seg0=7'b1111001 within 4 clocks of the last edge.
2. Same pattern; raise SW5,3,7,6, then lower SW3 -> done=1, pass=0, seg0=7'b1000000. Later switch changes leave seg0 unchanged.
3. Same pattern; after SW5, raise SW3 and SW7 in the same clock -> fail on that event; LED mirrors SW until DONE.
4. Hold SW0=1 through playback -> remains in WAIT_CLEAR with busy=1 and no timeout. Clear SW0, then make no input -> fail exactly TIMEOUT_CYCLES clocks after entering CAPTURE.
5. Assert rst mid-SHOW_ON at step 3 -> next edge LED=0, seg0=blank, busy=0; new round replays from step 0 with full ON_CYCLES.
6. AUTO_START=0: start pulse while busy is ignored; start in DONE -> seg0 blank on entry to SHOW_ON and a new pattern_in is latched.
